input_scheduler: RTL and testbench

INPUT_SCHEDULER -- requirements
Module: input_scheduler

---
 rtl/wino_pkg.sv | 26 ++
 rtl/sched_pair_counter.sv | 33 +++
 rtl/input_scheduler.sv | 158 +++++++++++++++
 tb/tb_input_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wino_pkg.sv
// Shared definitions for the input scheduler.
// Holds the scheduler state enum, the error codes reported on err_o and the
// default channel-index width.
package wino_pkg;

  localparam int DEF_CH_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_STREAM,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } sched_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_EMPTY   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Tile pairs expected per channel: ceil(tiles / 2).
  function automatic logic [15:0] half_ceil(input logic [15:0] n);
    return (n >> 1) + 16'(n[0]);
  endfunction

endpackage

// File: rtl/sched_pair_counter.sv
// Saturating tile-pair counter for the input scheduler.
// Counts increments up to limit_i and holds there; term_o flags count == limit.
module sched_pair_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             term_o
);

  logic [CNT_W-1:0] r_count;
  logic             w_term;

  assign w_term = (r_count == limit_i);
  assign term_o = w_term;

  // Count pairs, clearing on request and holding once the limit is reached.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    if (!reset) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (inc_i && !w_term) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/input_scheduler.sv
// Input scheduler: walks every input channel of a layer pass, pulsing the
// data controller once per channel and waiting until all tile pairs of that
// channel have been delivered.
// Optional feature: define SCHED_TIMEOUT_EN to add a DRAIN watchdog that
// aborts a stalled pass with err_o = 2.
module input_scheduler
  import wino_pkg::*;
#(
  parameter int CH_W           = DEF_CH_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [CH_W-1:0] num_channels_i,
  input  logic [7:0]      block_width_i,
  input  logic [7:0]      block_height_i,
  input  logic            size_type_i,
  input  logic            loop_finished_i,
  input  logic            data_valid_i,
  output logic [CH_W-1:0] input_id_o,
  output logic            input_prepare_o,
  output logic [7:0]      block_width_o,
  output logic [7:0]      block_height_o,
  output logic            size_type_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [1:0]      err_o
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic [CH_W-1:0] r_num_ch;
  logic [CH_W-1:0] r_id;
  logic [7:0]      r_bw;
  logic [7:0]      r_bh;
  logic            r_size;
  logic [15:0]     r_exp;
  logic [1:0]      r_err;

  logic [15:0] w_area;
  logic        w_empty;
  logic        w_last;
  logic        w_pairs_done;
  logic        w_cnt_clear;
  logic        w_cnt_inc;
  logic        w_timeout;

  assign w_area  = 16'(block_width_i) * 16'(block_height_i);
  assign w_empty = (num_channels_i == '0) || (w_area == 16'd0);
  assign w_last  = (r_id == r_num_ch - CH_W'(1));

  assign w_cnt_clear = (r_state == S_IDLE) || (r_state == S_NEXT);
  assign w_cnt_inc   = data_valid_i && ((r_state == S_STREAM) || (r_state == S_DRAIN));

  sched_pair_counter #(
    .CNT_W (16)
  ) u_pairs (
    .clk     (clk),
    .reset   (reset),
    .clear_i (w_cnt_clear),
    .inc_i   (w_cnt_inc),
    .limit_i (r_exp),
    .term_o  (w_pairs_done)
  );

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;

  // Count consecutive DRAIN cycles without a delivered pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wd <= '0;
    end else if ((r_state != S_DRAIN) || data_valid_i) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + WD_W'(1);
    end
  end

  assign w_timeout = (r_state == S_DRAIN) && !data_valid_i &&
                     (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort wins over everything else.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for states that do not change it.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start_i) w_state_nxt = w_empty ? S_DONE : S_PREP;
      S_PREP:   w_state_nxt = S_STREAM;
      S_STREAM: if (loop_finished_i) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_pairs_done) w_state_nxt = S_NEXT;
        else if (w_timeout) w_state_nxt = S_DONE;
      end
      S_NEXT:   w_state_nxt = w_last ? S_DONE : S_PREP;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (abort_i) w_state_nxt = S_IDLE;
  end

  // Pass configuration, channel index and error code.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_num_ch <= '0;
      r_id     <= '0;
      r_bw     <= '0;
      r_bh     <= '0;
      r_size   <= 1'b0;
      r_exp    <= '0;
      r_err    <= ERR_NONE;
    end else if (!abort_i) begin
      if ((r_state == S_IDLE) && start_i) begin
        r_num_ch <= num_channels_i;
        r_id     <= '0;
        r_bw     <= block_width_i;
        r_bh     <= block_height_i;
        r_size   <= size_type_i;
        r_exp    <= half_ceil(w_area);
        r_err    <= w_empty ? ERR_EMPTY : ERR_NONE;
      end
      if ((r_state == S_NEXT) && !w_last) begin
        r_id <= r_id + CH_W'(1);
      end
      if (w_timeout) begin
        r_err <= ERR_TIMEOUT;
      end
    end
  end

  assign input_id_o      = r_id;
  assign input_prepare_o = (r_state == S_PREP);
  assign block_width_o   = r_bw;
  assign block_height_o  = r_bh;
  assign size_type_o     = r_size;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = (r_state == S_DONE);
  assign err_o           = r_err;

endmodule

// File: tb/tb_input_scheduler.sv
// Self-checking bench for input_scheduler: a driver issues passes and pushes
// the expected prepare/done events; a monitor pops and compares them.
module tb_input_scheduler;

  localparam int CH_W = 4;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start_i = 1'b0;
  logic            abort_i = 1'b0;
  logic [CH_W-1:0] num_channels_i = '0;
  logic [7:0]      block_width_i = '0;
  logic [7:0]      block_height_i = '0;
  logic            size_type_i = 1'b0;
  logic            loop_finished_i = 1'b0;
  logic            data_valid_i = 1'b0;
  logic [CH_W-1:0] input_id_o;
  logic            input_prepare_o;
  logic [7:0]      block_width_o;
  logic [7:0]      block_height_o;
  logic            size_type_o;
  logic            busy_o;
  logic            done_o;
  logic [1:0]      err_o;

  always #5 clk = ~clk;

  input_scheduler #(.CH_W(CH_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .num_channels_i  (num_channels_i),
    .block_width_i   (block_width_i),
    .block_height_i  (block_height_i),
    .size_type_i     (size_type_i),
    .loop_finished_i (loop_finished_i),
    .data_valid_i    (data_valid_i),
    .input_id_o      (input_id_o),
    .input_prepare_o (input_prepare_o),
    .block_width_o   (block_width_o),
    .block_height_o  (block_height_o),
    .size_type_o     (size_type_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  typedef struct {
    bit is_done;
    int id;
    int err;
    int w;
    int h;
    int sz;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_total = 0;
  int  n_bad = 0;
  int  n_prep_seen = 0;
  int  n_done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every prepare or done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (input_prepare_o === 1'b1 || done_o === 1'b1) begin
      if (input_prepare_o) n_prep_seen++;
      if (done_o) n_done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, done_o, input_prepare_o}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", done_o, mon_e.is_done);
        if (mon_e.is_done) check("done_err", err_o, mon_e.err);
        else               check("prep_id", input_id_o, mon_e.id);
        check("cfg_w", block_width_o, mon_e.w);
        check("cfg_h", block_height_o, mon_e.h);
        check("cfg_sz", size_type_o, mon_e.sz);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one prepare per channel, then done; empty config -> done err 1.
  task automatic push_events(input int ch, input int w, input int h, input int sz, input int err);
    ev_t e;
    e.w = w; e.h = h; e.sz = sz; e.id = 0; e.err = 0;
    if (ch == 0 || w * h == 0) begin
      e.is_done = 1'b1; e.err = 1;
      exp_q.push_back(e);
    end else begin
      for (int c = 0; c < ch; c++) begin
        e.is_done = 1'b0; e.id = c;
        exp_q.push_back(e);
      end
      e.is_done = 1'b1; e.err = err;
      exp_q.push_back(e);
    end
  endtask

  // Pulse start for one cycle, then scramble the config inputs.
  task automatic start_pass(input int ch, input int w, input int h, input int sz, input int err);
    push_events(ch, w, h, sz, err);
    start_i        = 1'b1;
    num_channels_i = CH_W'(ch);
    block_width_i  = 8'(w);
    block_height_i = 8'(h);
    size_type_i    = sz[0];
    tick();
    start_i        = 1'b0;
    num_channels_i = CH_W'($urandom);
    block_width_i  = 8'($urandom);
    block_height_i = 8'($urandom);
    size_type_i    = 1'($urandom);
  endtask

  task automatic wait_prep();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (input_prepare_o) begin ok = 1'b1; break; end
    end
    check("prep_seen", ok, 1);
  endtask

  task automatic wait_done(input int bound, output int cycles);
    bit found = 1'b0;
    cycles = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      cycles++;
      if (done_o) begin found = 1'b1; break; end
    end
    check("done_seen", found, 1);
  endtask

  // Deliver one channel's pairs; called at the negedge of the PREP cycle.
  task automatic feed(input int exp_n, input bit sat);
    int ndv = sat ? exp_n + 2 : exp_n;
    int k   = sat ? ndv : int'($urandom_range(0, exp_n));
    tick();
    for (int i = 0; i < ndv; i++) begin
      if (i == k) begin loop_finished_i = 1'b1; tick(); loop_finished_i = 1'b0; end
      data_valid_i = 1'b1; tick(); data_valid_i = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end
    if (k >= ndv) begin loop_finished_i = 1'b1; tick(); loop_finished_i = 1'b0; end
  endtask

  task automatic run_pass(input int ch, input int w, input int h, input int sz, input bit sat);
    int cyc;
    start_pass(ch, w, h, sz, 0);
    if (ch != 0 && w * h != 0) begin
      for (int c = 0; c < ch; c++) begin
        wait_prep();
        feed((w * h + 1) / 2, sat);
      end
    end
    wait_done(80, cyc);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc, p0, d0;

    // Reset state.
    tick(); tick();
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_prep", input_prepare_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_id", input_id_o, 0);
    reset = 1'b1;
    tick();

    // Three channels, 4x2 tiles -> 4 pairs each.
    p0 = n_prep_seen; d0 = n_done_seen;
    start_pass(3, 4, 2, 1, 0);
    @(negedge clk);
    check("prep_latency", input_prepare_o, 1);
    check("busy_on", busy_o, 1);
    feed(4, 1'b0);
    for (int c = 1; c < 3; c++) begin
      wait_prep();
      feed(4, 1'b0);
    end
    wait_done(40, cyc);
    tick();
    check("t040_preps", n_prep_seen - p0, 3);
    check("t040_dones", n_done_seen - d0, 1);
    check("t040_idle", busy_o, 0);

    // 3x3 tiles -> 5 pairs; four pairs must leave the pass stuck in DRAIN.
    start_pass(1, 3, 3, 0, 0);
    wait_prep();
    tick();
    loop_finished_i = 1'b1; tick(); loop_finished_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_valid_i = 1'b1; tick(); data_valid_i = 1'b0; tick();
    end
    d0 = n_done_seen;
    repeat (10) tick();
    check("drain_hold_busy", busy_o, 1);
    check("drain_hold_nodone", n_done_seen - d0, 0);
    data_valid_i = 1'b1; tick(); data_valid_i = 1'b0;
    wait_done(6, cyc);
    tick();

    // Empty configuration: done one cycle after start, err 1, no prepare.
    p0 = n_prep_seen;
    start_pass(0, 5, 5, 0, 0);
    @(negedge clk);
    check("empty_done", done_o, 1);
    check("empty_err", err_o, 1);
    tick();
    repeat (3) tick();
    @(negedge clk);
    check("empty_err_hold", err_o, 1);
    check("empty_noprep", n_prep_seen - p0, 0);
    run_pass(2, 0, 3, 1, 1'b0);

    // Abort in STREAM together with start.
    start_pass(2, 4, 2, 0, 0);
    wait_prep();
    tick();
    abort_i = 1'b1; start_i = 1'b1;
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    repeat (6) tick();

`ifdef SCHED_TIMEOUT_EN
    // DRAIN stall: done with err 2 after TO idle cycles.
    start_pass(1, 2, 2, 0, 2);
    wait_prep();
    tick();
    loop_finished_i = 1'b1; tick(); loop_finished_i = 1'b0;
    wait_done(40, cyc);
    check("timeout_cycles", cyc, TO + 1);
    tick();
`endif

    // Reset mid-DRAIN, then a normal pass.
    start_pass(1, 4, 2, 1, 0);
    wait_prep();
    tick();
    loop_finished_i = 1'b1; tick(); loop_finished_i = 1'b0;
    data_valid_i = 1'b1; tick(); data_valid_i = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_id", input_id_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_bw", block_width_o, 0);
    check("mid_rst_bh", block_height_o, 0);
    check("mid_rst_sz", size_type_o, 0);
    tick();
    run_pass(2, 3, 2, 0, 1'b0);

    // Randomised passes, some oversupplying pairs to exercise saturation.
    for (int n = 0; n < 10; n++) begin
      run_pass(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
               int'($urandom_range(1, 6)), int'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0));
    end

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
